// File: rtl/loader_pkg.sv
// Shared types and frame constants for the instruction-memory boot loader.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    localparam int unsigned DEFAULT_DEPTH  = 1024;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned MAX_WORDS      = DEFAULT_DEPTH / BYTES_PER_WORD;
    localparam int unsigned LEN_W          = 16;
    localparam int unsigned BYTE_W         = 8;

    // Largest legal word count for a memory of the given byte depth.
    function automatic logic [LEN_W-1:0] max_words(input int unsigned depth);
        return LEN_W'(depth / BYTES_PER_WORD);
    endfunction

endpackage

// File: rtl/loader_csum8.sv
// 8-bit XOR accumulator used to check the frame payload checksum.
module loader_csum8
    import loader_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [BYTE_W-1:0] data_i,
    output logic [BYTE_W-1:0] acc_o
);

    logic [BYTE_W-1:0] acc_q, acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q ^ data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/insmem_loader.sv
// Framed byte-stream loader for the byte-wide instruction memory; holds the
// CPU until a frame with a matching checksum has been written.
module insmem_loader
    import loader_pkg::*;
#(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic              start,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam int unsigned      CNT_W       = ADDR_W + 1;
    localparam logic [LEN_W-1:0] WORDS_LIMIT = max_words(DEPTH);

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   n_q, n_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [BYTE_W-1:0]  wdata_q, wdata_d;

    logic               acc_clr, acc_en;
    logic [BYTE_W-1:0]  acc;
    logic               fire;
    logic [LEN_W-1:0]   n_full;
    logic [CNT_W-1:0]   bytes_total;

    assign fire   = rx_valid && rx_ready;
    assign n_full = {n_q[LEN_W-1:BYTE_W], rx_data};
    // N is already bounded by WORDS_LIMIT here, so its low bits times 4 fit the counter.
    assign bytes_total = {n_q[ADDR_W-2:0], 2'b00};

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        acc_clr = 1'b0;
        acc_en  = 1'b0;
        case (state_q)
            IDLE: state_d = LEN_HI;
            LEN_HI: begin
                if (fire) begin
                    n_d     = {rx_data, 8'h00};
                    state_d = LEN_LO;
                end
            end
            LEN_LO: begin
                if (fire) begin
                    n_d     = n_full;
                    cnt_d   = '0;
                    acc_clr = 1'b1;
                    if (n_full > WORDS_LIMIT) begin
                        state_d = ERR;
                    end else if (n_full == '0) begin
                        state_d = CSUM;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (fire) begin
                    we_d    = 1'b1;
                    addr_d  = cnt_q[ADDR_W-1:0];
                    wdata_d = rx_data;
                    acc_en  = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q + CNT_W'(1) == bytes_total) begin
                        state_d = CSUM;
                    end
                end
            end
            CSUM: begin
                if (fire) begin
                    state_d = (rx_data == acc) ? DONE : ERR;
                end
            end
            DONE, ERR: begin
                if (start) begin
                    state_d = LEN_HI;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            n_q     <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    loader_csum8 u_csum (
        .clk_i  (CLK),
        .rst_i  (RST),
        .clr_i  (acc_clr),
        .en_i   (acc_en),
        .data_i (rx_data),
        .acc_o  (acc)
    );

    assign rx_ready  = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                       (state_q == DATA)   || (state_q == CSUM);
    assign cpu_hold  = (state_q != DONE);
    assign done      = (state_q == DONE);
    assign err       = (state_q == ERR);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_insmem_loader.sv
// Scoreboard bench for insmem_loader: frames are issued with random gaps and
// expected writes/outcomes come from a frame-level reference model.
module tb_insmem_loader;

    logic       CLK = 1'b0;
    logic       RST;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       start;
    logic       mem_we;
    logic [9:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_hold;
    logic       done;
    logic       err;

    insmem_loader #(.DEPTH(1024), .ADDR_W(10)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .start     (start),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [9:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] frame[$];
    int         checks   = 0;
    int         failures = 0;
    int         wr_seen  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge CLK) begin
        if (!RST && mem_we) begin
            wr_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr %0h data %0h, expected none", mem_addr, mem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(e.a));
                chk("wr_data", 32'(mem_wdata), 32'(e.d));
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rx_ready"}, 32'(rx_ready), 0);
        chk({tag, "_mem_we"}, 32'(mem_we), 0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), 1);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err"}, 32'(err), 0);
    endtask

    // Present a byte (after an optional idle gap) and hold it until accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        if (gap > 0) begin
            rx_valid = 1'b0;
            repeat (gap) @(posedge CLK);
            #1;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        t = 0;
        @(negedge CLK);
        while (!rx_ready && t < 50) begin
            t++;
            @(negedge CLK);
        end
        if (!rx_ready) begin
            checks++;
            failures++;
            $display("FAIL rx_ready_timeout: got rx_ready 0 for 50 cycles, expected 1");
        end else begin
            chk("hold_during_load", 32'(cpu_hold), 1);
        end
        @(posedge CLK);
        #1;
    endtask

    function automatic int pick_gap(input int mode);
        if (mode == 1) return 1;
        if (mode == 2) return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        return 0;
    endfunction

    // Issue the frame in `frame` and check the outcome the frame rules predict.
    task automatic run_frame(input int mode);
        int unsigned n;
        logic [7:0]  x;
        logic        good;
        n = {frame[0], frame[1]};
        send_byte(frame[0], pick_gap(mode));
        send_byte(frame[1], pick_gap(mode));
        if (n > 256) begin
            rx_valid = 1'b0;
            chk("oversize_err", 32'(err), 1);
            chk("oversize_done", 32'(done), 0);
            chk("oversize_ready", 32'(rx_ready), 0);
            chk("oversize_hold", 32'(cpu_hold), 1);
        end else begin
            x = 8'h00;
            for (int unsigned i = 0; i < 4 * n; i++) begin
                exp_q.push_back(wr_t'{a: 10'(i), d: frame[2+i]});
                x = x ^ frame[2+i];
                send_byte(frame[2+i], pick_gap(mode));
            end
            send_byte(frame[2+4*n], pick_gap(mode));
            rx_valid = 1'b0;
            good = (frame[2+4*n] == x);
            chk("end_done", 32'(done), 32'(good));
            chk("end_err", 32'(err), 32'(!good));
            chk("end_hold", 32'(cpu_hold), 32'(!good));
            chk("end_ready", 32'(rx_ready), 0);
            chk("pending_writes", 32'(exp_q.size()), 0);
        end
    endtask

    task automatic pulse_start(input logic [7:0] first);
        start    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = first;
        @(posedge CLK);
        #1;
        start    = 1'b0;
        rx_valid = 1'b0;
        chk("start_done", 32'(done), 0);
        chk("start_err", 32'(err), 0);
        chk("start_hold", 32'(cpu_hold), 1);
        chk("start_ready", 32'(rx_ready), 1);
    endtask

    task automatic build_random(input int unsigned n, input logic bad);
        logic [7:0] x, b;
        frame = {};
        frame.push_back(n[15:8]);
        frame.push_back(n[7:0]);
        x = 8'h00;
        if (n <= 256) begin
            for (int unsigned i = 0; i < 4 * n; i++) begin
                b = 8'($urandom);
                frame.push_back(b);
                x = x ^ b;
            end
            frame.push_back(bad ? (x ^ 8'(int'($urandom_range(1, 255)))) : x);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        RST      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        start    = 1'b0;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // Nominal load
        frame = {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h2D};
        w0 = wr_seen;
        run_frame(0);
        chk("nominal_write_count", 32'(wr_seen - w0), 8);

        // Bad checksum
        frame[10] = 8'h2C;
        pulse_start(frame[0]);
        w0 = wr_seen;
        run_frame(0);
        chk("badcsum_write_count", 32'(wr_seen - w0), 8);

        // Oversize length, then bytes must not be accepted
        frame = {8'h01, 8'h01};
        pulse_start(frame[0]);
        w0 = wr_seen;
        run_frame(0);
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("oversize_no_accept", 32'(rx_ready), 0);
        end
        @(posedge CLK);
        #1;
        rx_valid = 1'b0;
        chk("oversize_write_count", 32'(wr_seen - w0), 0);

        // Zero length
        frame = {8'h00, 8'h00, 8'h00};
        pulse_start(frame[0]);
        w0 = wr_seen;
        run_frame(0);
        chk("zero_write_count", 32'(wr_seen - w0), 0);

        // Nominal frame with rx_valid toggling every cycle
        frame = {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h2D};
        pulse_start(frame[0]);
        w0 = wr_seen;
        run_frame(1);
        chk("toggle_write_count", 32'(wr_seen - w0), 8);

        // Reset after the third payload byte
        pulse_start(frame[0]);
        send_byte(frame[0], 0);
        send_byte(frame[1], 0);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(wr_t'{a: 10'(i), d: frame[2+i]});
            send_byte(frame[2+i], 0);
        end
        rx_valid = 1'b0;
        RST = 1'b1;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        w0 = wr_seen;
        run_frame(0);
        chk("postreset_write_count", 32'(wr_seen - w0), 8);

        // Reload; the byte presented alongside start must not be consumed
        frame = {8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
        pulse_start(frame[0]);
        run_frame(0);

        // Full-depth frame and the first illegal length
        build_random(256, 1'b0);
        pulse_start(frame[0]);
        run_frame(0);
        build_random(257, 1'b0);
        pulse_start(frame[0]);
        run_frame(0);

        // Randomized frames with random gaps
        for (int k = 0; k < 24; k++) begin
            int unsigned n;
            if ($urandom_range(0, 7) == 0) n = $urandom_range(257, 65535);
            else n = $urandom_range(0, 6);
            build_random(n, $urandom_range(0, 3) == 0);
            pulse_start(frame[0]);
            run_frame(2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/insmem_loader.md
# insmem_loader

Boot-time writer for the byte-wide instruction memory that the single-cycle MIPS fetch path reads. It accepts a framed byte stream over a valid/ready handshake and writes each payload byte sequentially from address 0. Bytes are written in big-endian order, matching fetch, which reads `insmem[dir]` as instruction bits 31:24. The block holds the CPU (PC/register-file write enable) inactive until a frame loads with a correct checksum.

## Interface
Parameters:
- `DEPTH`, 1024: instruction memory size in bytes; must be a multiple of 4.
- `ADDR_W`, 10: byte-address width, equal to clog2(DEPTH).

Ports:
- `CLK`, in, 1: the single clock; all state updates on the rising edge.
- `RST`, in, 1: asynchronous, active-high reset.
- `rx_valid`, in, 1: the source presents a byte.
- `rx_data`, in, 8: the byte.
- `rx_ready`, out, 1: the loader can accept a byte.
- `start`, in, 1: pulse that re-arms loading; honoured only in DONE or ERR.
- `mem_we`, out, 1: one-cycle write strobe to the instruction memory.
- `mem_addr`, out, ADDR_W: byte address for the write.
- `mem_wdata`, out, 8: byte to write.
- `cpu_hold`, out, 1: holds the CPU; 1 means stalled.
- `done`, out, 1: a frame loaded successfully.
- `err`, out, 1: the frame was rejected because of a bad length or checksum.

## Operation
- Frame format, in order:
  - LEN_HI, then LEN_LO: N, a 16-bit word count, big-endian.
  - 4·N payload bytes.
  - CSUM: the XOR of all payload bytes.
- A byte is accepted on a rising edge with `rx_valid && rx_ready`.
- States:
  - IDLE: after reset; `rx_ready`=0. Moves to LEN_HI unconditionally on the next edge.
  - LEN_HI: accept a byte, store it in the high byte of N, go to LEN_LO.
  - LEN_LO: accept a byte, complete N, then:
    - N > DEPTH/4: go to ERR.
    - N == 0: go to CSUM.
    - Otherwise: go to DATA, with the byte counter and the XOR accumulator set to 0.
  - DATA: for each accepted byte, write it at `mem_addr` = byte counter, XOR it into the accumulator, and increment the counter. After byte 4·N−1 is accepted, go to CSUM.
  - CSUM: accept a byte. If it equals the accumulator, go to DONE; otherwise go to ERR.
  - DONE: `done`=1, `cpu_hold`=0, `rx_ready`=0.
  - ERR: `err`=1, `cpu_hold`=1, `rx_ready`=0.
- `rx_ready`=1 only in LEN_HI, LEN_LO, DATA and CSUM. It depends on state only, never on `rx_valid`.
- `start` in DONE or ERR:
  - Moves to LEN_HI and clears `done` and `err` on the same edge.
  - Sets `cpu_hold`=1 on that edge.
  - Ignored in all other states.
- Width rules:
  - The byte counter is ADDR_W+1 bits, so 4·N = DEPTH is reached without wrap. The written address never exceeds DEPTH−1.
  - N is compared as unsigned 16-bit.
- Partial writes from an aborted frame are not undone. Memory contents after ERR are undefined for software.
- Reset values: `rx_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_hold`=1, `done`=0, `err`=0; state IDLE; counter, N and accumulator 0.

## Timing
- Throughput is one byte per cycle when `rx_valid` is held high. Gaps in `rx_valid` stall without loss.
- Write latency is 1 cycle. `mem_we`, `mem_addr` and `mem_wdata` are registered and asserted in the cycle after the DATA handshake. `mem_we` is 0 in every other cycle.
- `done` or `err` rises in the cycle after the CSUM handshake.
- A bad-length `err` rises in the cycle after the LEN_LO handshake. No `mem_we` pulses occur for that frame.
- `cpu_hold` falls on the same edge that `done` rises.
- `RST` mid-frame forces all outputs to their reset values immediately, asynchronously. Loading restarts with the LEN_HI of a fresh frame.
- `start` and a byte arriving together in DONE or ERR: the byte is not accepted, because `rx_ready` was 0 in that cycle.

## Structure
- Shared package `loader_pkg` holds:
  - the state enum: IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR;
  - `MAX_WORDS` = DEPTH/4;
  - the frame-field constants.
- One natural sub-module, `loader_csum8`: an 8-bit XOR accumulator with clear and enable inputs.
- Everything else lives in one FSM module with the counter and registered write port.

## Test plan
- Nominal load: after reset, send 00 02 20 08 00 05 00 00 00 00 2D. Required response:
  - writes to addresses 0..7 of 20, 08, 00, 05, 00, 00, 00, 00;
  - `done`=1 and `cpu_hold`=0 one cycle after 2D;
  - exactly 8 `mem_we` pulses.
- Bad checksum: the same frame with a final byte of 2C. Required response: 8 writes, then `err`=1, `done`=0, `cpu_hold`=1, `rx_ready`=0.
- Oversize length: send 01 01. Required response: `err`=1 one cycle after the second byte, zero `mem_we` pulses, further bytes not accepted.
- Zero length and back-pressure:
  - 00 00 00 gives `done`=1 with no writes.
  - Repeat the nominal frame with `rx_valid` toggling every cycle; it gives identical writes.
- Reset mid-DATA: assert `RST` after the 3rd payload byte. Required response: all outputs are at reset values immediately; a full nominal frame sent next loads correctly.
- Reload: in DONE, pulse `start`, then send 00 01 AA BB CC DD 00 (AA^BB^CC^DD=00). Required response: `cpu_hold`=1 during the load, addresses 0..3 = AA BB CC DD, then `done`=1.
